// File: rtl/iiitb_fifo_uart_tx.sv
// iiitb_fifo_uart_tx: drains iiitb_sync_fifo one byte at a time and serializes
// each byte onto a UART line as 8N1 (start, 8 data bits LSB-first, stop).
// One FIFO pop per transmitted frame gives the FIFO real back-pressure.
//
// Ports:
//   CLK        system clock, rising edge
//   RSTn       asynchronous active-low reset
//   en         drain enable, sampled only while idle
//   empty      FIFO empty flag
//   fifo_data  FIFO read data (valid in the cycle after the pop strobe)
//   read       FIFO pop strobe, one cycle per frame (registered)
//   tx         serial line, idles high (registered)
//   busy       high whenever a frame is being fetched or sent (registered)
module iiitb_fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       en,
  input  logic       empty,
  input  logic [7:0] fifo_data,
  output logic       read,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [2:0]       r_bit,   w_bit_nxt;
  logic [7:0]       r_shreg, w_shreg_nxt;
  logic             r_read, r_tx, r_busy;
  logic             w_tick;
  logic             w_tx_nxt;

  // State and datapath registers; outputs are derived from the next state so
  // they line up exactly with the state they describe.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_read  <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
      r_read  <= (w_state_nxt == S_REQ);
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Next-state, baud counter, bit index and shift register.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    w_tick      = (r_cnt == CNT_LAST);

    case (r_state)
      S_IDLE: begin
        if (en && !empty) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // FIFO data is valid for the whole cycle after the pop strobe.
        w_shreg_nxt = fifo_data;
        w_cnt_nxt   = '0;
        w_state_nxt = S_START;
      end
      S_START: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_shreg_nxt = {1'b0, r_shreg[7:1]};
          // Index holds at 7 into STOP so it never wraps within a frame.
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Line level for the upcoming cycle.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shreg_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign read = r_read;
  assign tx   = r_tx;
  assign busy = r_busy;

endmodule

// File: tb/tb_iiitb_fifo_uart_tx.sv
// Bench for iiitb_fifo_uart_tx: two instances (CLKS_PER_BIT=4 and =2), each
// fed by a behavioural FIFO; expected bytes are queued when pushed and
// compared against frames decoded from the tx line.
module tb_iiitb_fifo_uart_tx;

  localparam int CPB0 = 4;
  localparam int CPB1 = 2;

  logic CLK  = 1'b0;
  logic RSTn = 1'b1;
  logic en   = 1'b0;

  logic       empty0 = 1'b1, empty1 = 1'b1;
  logic [7:0] fd0 = 8'h00, fd1 = 8'h00;
  logic       read0, tx0, busy0, read1, tx1, busy1;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  logic [7:0] fq0[$], fq1[$], exp0[$], exp1[$];
  int rd_cyc0[$];
  int rd_cyc1[$];
  int rd_cnt0 = 0, rd_cnt1 = 0, rd_long = 0;
  logic prev_rd0 = 1'b0, prev_rd1 = 1'b0;

  iiitb_fifo_uart_tx #(.CLKS_PER_BIT(CPB0)) u_dut0 (
    .CLK(CLK), .RSTn(RSTn), .en(en), .empty(empty0), .fifo_data(fd0),
    .read(read0), .tx(tx0), .busy(busy0)
  );

  iiitb_fifo_uart_tx #(.CLKS_PER_BIT(CPB1)) u_dut1 (
    .CLK(CLK), .RSTn(RSTn), .en(en), .empty(empty1), .fifo_data(fd1),
    .read(read1), .tx(tx1), .busy(busy1)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural FIFOs: pop on a sampled read, data valid the following cycle.
  always @(posedge CLK) begin
    if (read0 && fq0.size() > 0) fd0 <= fq0.pop_front();
    empty0 <= (fq0.size() == 0);
  end

  always @(posedge CLK) begin
    if (read1 && fq1.size() > 0) fd1 <= fq1.pop_front();
    empty1 <= (fq1.size() == 0);
  end

  // Read-strobe monitor: records pulse cycles and flags multi-cycle pulses.
  always @(negedge CLK) begin
    if (read0) begin
      rd_cnt0 <= rd_cnt0 + 1;
      rd_cyc0.push_back(cyc);
    end
    if (read1) begin
      rd_cnt1 <= rd_cnt1 + 1;
      rd_cyc1.push_back(cyc);
    end
    if ((read0 && prev_rd0) || (read1 && prev_rd1)) rd_long <= rd_long + 1;
    prev_rd0 <= read0;
    prev_rd1 <= read1;
  end

  function automatic logic get_tx(input int k);
    return (k == 0) ? tx0 : tx1;
  endfunction

  function automatic int last_rd(input int k, input int back);
    if (k == 0) return (rd_cyc0.size() > back) ? rd_cyc0[rd_cyc0.size()-1-back] : -1000;
    return (rd_cyc1.size() > back) ? rd_cyc1[rd_cyc1.size()-1-back] : -1000;
  endfunction

  // Decode one 8N1 frame; ok=0 if any bit is not constant for cpb cycles,
  // framing is wrong, or no start bit appears in time.
  task automatic get_frame(input int k, input int cpb, output logic [7:0] b,
                           output logic ok, output int t0);
    logic [9:0] bits;
    logic v;
    int n;
    ok = 1'b1; b = 8'h00; t0 = -1; n = 0; bits = '0;
    while (get_tx(k) !== 1'b0 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 2000) begin
      ok = 1'b0;
      return;
    end
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < cpb; j++) begin
        if (!(i == 0 && j == 0)) @(negedge CLK);
        v = get_tx(k);
        if (j == 0) bits[i] = v;
        else if (v !== bits[i]) ok = 1'b0;
      end
    end
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
    b = bits[8:1];
  endtask

  task automatic wait_read0(output int n);
    n = 0;
    while (read0 !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic test_reset;
    #1 RSTn = 1'b0;
    #1;
    vectors++;
    if (tx0 !== 1'b1 || read0 !== 1'b0 || busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset0: tx=%b read=%b busy=%b, want 1 0 0", tx0, read0, busy0);
    end
    vectors++;
    if (tx1 !== 1'b1 || read1 !== 1'b0 || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset1: tx=%b read=%b busy=%b, want 1 0 0", tx1, read1, busy1);
    end
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    vectors++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || rd_cnt0 !== 0) begin
      miscompares++;
      $display("FAIL post_reset_idle: tx=%b busy=%b reads=%0d, want 1 0 0", tx0, busy0, rd_cnt0);
    end
  endtask

  task automatic test_single_byte;
    logic [7:0] b, e;
    logic ok;
    int t0, r0;
    r0 = rd_cnt0;
    fq0.push_back(8'hA5); exp0.push_back(8'hA5);
    en = 1'b1;
    get_frame(0, CPB0, b, ok, t0);
    e = (exp0.size() > 0) ? exp0.pop_front() : 8'hxx;
    vectors++;
    if (b !== e || ok !== 1'b1) begin
      miscompares++;
      $display("FAIL single_byte: got %h ok=%b, want %h ok=1", b, ok, e);
    end
    vectors++;
    if (t0 - last_rd(0, 0) !== 2) begin
      miscompares++;
      $display("FAIL first_latency: read->start %0d cycles, want 2", t0 - last_rd(0, 0));
    end
    repeat (3) @(negedge CLK);
    vectors++;
    if (busy0 !== 1'b0 || tx0 !== 1'b1 || rd_cnt0 - r0 !== 1) begin
      miscompares++;
      $display("FAIL single_after: busy=%b tx=%b reads=%0d, want 0 1 1", busy0, tx0, rd_cnt0 - r0);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b, e;
    logic ok;
    int t0, tp, r0;
    r0 = rd_cnt0; tp = 0;
    for (int i = 1; i <= 3; i++) begin
      fq0.push_back(8'(i)); exp0.push_back(8'(i));
    end
    for (int i = 0; i < 3; i++) begin
      get_frame(0, CPB0, b, ok, t0);
      e = (exp0.size() > 0) ? exp0.pop_front() : 8'hxx;
      vectors++;
      if (b !== e || ok !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_byte%0d: got %h ok=%b, want %h ok=1", i, b, ok, e);
      end
      if (i > 0) begin
        vectors++;
        if (t0 - (tp + 10 * CPB0) !== 3) begin
          miscompares++;
          $display("FAIL b2b_gap%0d: %0d idle cycles, want 3", i, t0 - (tp + 10 * CPB0));
        end
      end
      tp = t0;
    end
    repeat (60) @(negedge CLK);
    vectors++;
    if (rd_cnt0 - r0 !== 3 || empty0 !== 1'b1 || busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: reads=%0d empty=%b busy=%b, want 3 1 0", rd_cnt0 - r0, empty0, busy0);
    end
    vectors++;
    if (last_rd(0, 0) - last_rd(0, 1) !== 43 || last_rd(0, 1) - last_rd(0, 2) !== 43) begin
      miscompares++;
      $display("FAIL b2b_read_spacing: %0d,%0d, want 43,43",
               last_rd(0, 1) - last_rd(0, 2), last_rd(0, 0) - last_rd(0, 1));
    end
  endtask

  task automatic test_empty;
    en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      vectors++;
      if (read0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) begin
        miscompares++;
        $display("FAIL empty_idle cyc%0d: read=%b tx=%b busy=%b, want 0 1 0", i, read0, tx0, busy0);
      end
    end
  endtask

  task automatic test_enable_gating;
    logic [7:0] b, e;
    logic ok;
    int t0, r0, c, n;
    r0 = rd_cnt0;
    fq0.push_back(8'h3C); exp0.push_back(8'h3C);
    fq0.push_back(8'h55); exp0.push_back(8'h55);
    en = 1'b1;
    fork
      get_frame(0, CPB0, b, ok, t0);
      begin
        wait_read0(n);
        repeat (18) @(negedge CLK);
        en = 1'b0;
      end
    join
    e = (exp0.size() > 0) ? exp0.pop_front() : 8'hxx;
    vectors++;
    if (b !== e || ok !== 1'b1) begin
      miscompares++;
      $display("FAIL gate_frame: got %h ok=%b, want %h ok=1", b, ok, e);
    end
    repeat (100) @(negedge CLK);
    vectors++;
    if (rd_cnt0 - r0 !== 1 || busy0 !== 1'b0 || tx0 !== 1'b1) begin
      miscompares++;
      $display("FAIL gate_hold: reads=%0d busy=%b tx=%b, want 1 0 1", rd_cnt0 - r0, busy0, tx0);
    end
    c = cyc;
    en = 1'b1;
    get_frame(0, CPB0, b, ok, t0);
    e = (exp0.size() > 0) ? exp0.pop_front() : 8'hxx;
    vectors++;
    if (b !== e || ok !== 1'b1) begin
      miscompares++;
      $display("FAIL gate_resume: got %h ok=%b, want %h ok=1", b, ok, e);
    end
    vectors++;
    if (last_rd(0, 0) !== c + 1 || t0 !== c + 3) begin
      miscompares++;
      $display("FAIL gate_latency: read@+%0d start@+%0d, want +1 +3", last_rd(0, 0) - c, t0 - c);
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] b, e;
    logic ok;
    int t0, r0, n;
    r0 = rd_cnt0;
    fq0.push_back(8'h11); exp0.push_back(8'h11);
    fq0.push_back(8'h22); exp0.push_back(8'h22);
    en = 1'b1;
    wait_read0(n);
    repeat (19) @(negedge CLK);
    #2 RSTn = 1'b0;
    #1;
    vectors++;
    if (tx0 !== 1'b1 || read0 !== 1'b0 || busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: tx=%b read=%b busy=%b, want 1 0 0", tx0, read0, busy0);
    end
    if (exp0.size() > 0) void'(exp0.pop_front());
    @(negedge CLK);
    RSTn = 1'b1;
    get_frame(0, CPB0, b, ok, t0);
    e = (exp0.size() > 0) ? exp0.pop_front() : 8'hxx;
    vectors++;
    if (b !== e || ok !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_next_frame: got %h ok=%b, want %h ok=1", b, ok, e);
    end
    vectors++;
    if (rd_cnt0 - r0 !== 2 || t0 - last_rd(0, 0) !== 2) begin
      miscompares++;
      $display("FAIL reset_reads: reads=%0d latency=%0d, want 2 2", rd_cnt0 - r0, t0 - last_rd(0, 0));
    end
  endtask

  task automatic test_param_corner;
    logic [7:0] b, e;
    logic ok;
    int t0, tp, r1;
    r1 = rd_cnt1; tp = 0;
    fq1.push_back(8'hFF); exp1.push_back(8'hFF);
    fq1.push_back(8'h00); exp1.push_back(8'h00);
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      get_frame(1, CPB1, b, ok, t0);
      e = (exp1.size() > 0) ? exp1.pop_front() : 8'hxx;
      vectors++;
      if (b !== e || ok !== 1'b1) begin
        miscompares++;
        $display("FAIL cpb2_byte%0d: got %h ok=%b, want %h ok=1", i, b, ok, e);
      end
      if (i > 0) begin
        vectors++;
        if (t0 - tp !== 10 * CPB1 + 3) begin
          miscompares++;
          $display("FAIL cpb2_period: %0d cycles, want %0d", t0 - tp, 10 * CPB1 + 3);
        end
      end
      tp = t0;
    end
    repeat (10) @(negedge CLK);
    vectors++;
    if (rd_cnt1 - r1 !== 2 || busy1 !== 1'b0 || tx1 !== 1'b1 || rd_long !== 0) begin
      miscompares++;
      $display("FAIL cpb2_end: reads=%0d busy=%b tx=%b long_reads=%0d, want 2 0 1 0",
               rd_cnt1 - r1, busy1, tx1, rd_long);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_empty();
    test_enable_gating();
    test_async_reset();
    test_param_corner();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iiitb_fifo_uart_tx.md
# iiitb_fifo_uart_tx

Downstream drain stage for `iiitb_sync_fifo`: whenever the FIFO is not empty, it pops one byte and serializes it onto a UART line as 8N1 (one start bit, eight data bits LSB-first, one stop bit). It drives the FIFO's `read` input and consumes its `oData`/`empty` outputs directly. It gives the FIFO a real consumer with back-pressure: one pop per transmitted frame.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal range is ≥2. The baud counter width is `$clog2(CLKS_PER_BIT)`.
- `CLK` in, 1 bit: system clock. All state updates on the rising edge.
- `RSTn` in, 1 bit: reset. One clock; reset is asynchronous and active-low.
- `en` in, 1 bit: drain enable. Sampled only in IDLE.
- `empty` in, 1 bit: FIFO empty flag.
- `fifo_data` in, 8 bits: FIFO `oData`.
- `read` out, 1 bit: FIFO pop strobe. Registered.
- `tx` out, 1 bit: serial line. Registered; idles high.
- `busy` out, 1 bit: high whenever state ≠ IDLE.

## Operation
- **States:** IDLE, REQ, WAIT, START, DATA, STOP.
- **IDLE → REQ:** when `en && !empty`. Otherwise stay in IDLE.
- **REQ:** `read`=1 for exactly this one cycle. Next state is WAIT unconditionally.
- **FIFO read latency contract:** the FIFO samples `read` at the edge ending REQ, and `fifo_data` is valid throughout WAIT.
- **WAIT:** capture `fifo_data` into an 8-bit shift register at the edge ending WAIT. Load the baud counter to 0. Go to START.
- **START:** `tx`=0 for `CLKS_PER_BIT` cycles. Then go to DATA with bit index 0.
- **DATA:** `tx`=shreg[0] for `CLKS_PER_BIT` cycles per bit, then shift right. After bit index 7 completes, go to STOP. The bit index is 3 bits and never wraps inside a frame.
- **STOP:** `tx`=1 for `CLKS_PER_BIT` cycles. Then go to IDLE.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1. Terminal count advances the bit or state, and the counter returns to 0.
- **`read` is never asserted:**
  - outside REQ;
  - when `empty`=1 was sampled in IDLE;
  - more than once per frame.
- **Mid-frame changes of `en` or `empty`:** ignored. The current frame always completes.
- **Reset mid-operation:** the in-flight byte is discarded (it was already popped). There is no retry.

## Timing
- **Reset values:** `tx`=1, `read`=0, `busy`=0, state=IDLE, counters=0, shreg=0. They take effect immediately on `RSTn` falling, without waiting for a clock.
- **First frame latency:** in the IDLE cycle where `en && !empty`, `read` rises at the next edge. `tx` falls (start bit) 2 cycles after `read` rises.
- **Frame length:** 10×`CLKS_PER_BIT` cycles from `tx` falling to the end of the stop bit.
- **Back-to-back frames:** after STOP ends, the line stays high for exactly 3 extra cycles (IDLE, REQ, WAIT) before the next start bit. Byte period is 10×`CLKS_PER_BIT`+3 cycles.
- **`busy`:** rises with the entry into REQ and falls with the entry into IDLE.
- **Last byte:** if `empty` rises in the same cycle as the pop, the current frame completes and the block then stays in IDLE.

## Test plan
- **Single byte:** `CLKS_PER_BIT`=4, FIFO holds 0xA5, `en`=1.
  - Exactly one 1-cycle `read` pulse.
  - `tx` sequence in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1.
  - `busy` then drops and `tx` stays 1.
- **Back-to-back:** FIFO preloaded with 0x01,0x02,0x03.
  - Three `read` pulses spaced 43 cycles apart.
  - Decoded bytes 0x01,0x02,0x03 in order.
  - Exactly 3 high cycles between each stop bit and the next start bit.
  - `empty`=1 after the third pop, with no fourth `read`.
- **Empty FIFO:** `empty`=1 and `en`=1 for 200 cycles. `read`=0, `tx`=1 and `busy`=0 throughout.
- **Enable gating:** FIFO holds 0x3C and 0x55; drop `en` mid-way through the 0x3C data bits.
  - The 0x3C frame completes intact.
  - No `read` while `en`=0.
  - Re-raising `en` pops 0x55 with first-frame latency.
- **Async reset mid-frame:** assert `RSTn`=0 between clock edges during data bit 3.
  - `tx`=1, `read`=0 and `busy`=0 immediately.
  - After release with a non-empty FIFO, the next byte starts a clean frame. The aborted byte is not resent.
- **Parameter corner:** `CLKS_PER_BIT`=2 with 0xFF then 0x00.
  - Bit periods are exactly 2 cycles.
  - Frames read 0,1×8,1 and 0,0×8,1.
